syn_cntr_n: RTL and testbench

//  Parametrised synchronous up/down counter with preset, parallel load, programmable

---
 rtl/syn_cntr_n_pkg.sv | 27 ++
 rtl/syn_cntr_n_step.sv | 38 +++
 rtl/syn_cntr_n.sv | 82 ++++++++
 tb/tb_syn_cntr_n.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/syn_cntr_n_pkg.sv
// Shared definitions for the syn_cntr_n counter: boundary modes and the
// per-edge operation priority (clear > preset > load > count > hold).
package syn_cntr_n_pkg;

    localparam bit CntrModeWrap = 1'b0;
    localparam bit CntrModeSat  = 1'b1;

    typedef enum logic [2:0] {
        OpClr,
        OpPre,
        OpLoad,
        OpCount,
        OpHold
    } cntr_op_e;

    function automatic cntr_op_e cntr_op_decode(input logic clr, input logic pre,
                                                input logic pl, input logic en);
        cntr_op_e op;
        if (clr)      op = OpClr;
        else if (pre) op = OpPre;
        else if (pl)  op = OpLoad;
        else if (en)  op = OpCount;
        else          op = OpHold;
        return op;
    endfunction

endpackage

// File: rtl/syn_cntr_n_step.sv
// Combinational next-count and boundary-event logic for one counting step.
module syn_cntr_n_step
    import syn_cntr_n_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = CntrModeWrap
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             up_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             bnd_o
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    always_comb begin
        nxt_o = q_i;
        bnd_o = 1'b0;
        if (up_i) begin
            // Anything at or above LIMIT (e.g. after a load) is a boundary event.
            if (q_i < limit_i) begin
                nxt_o = q_i + One;
            end else begin
                bnd_o = 1'b1;
                nxt_o = (SATURATE == CntrModeSat) ? limit_i : '0;
            end
        end else begin
            if (q_i != '0) begin
                nxt_o = q_i - One;
            end else begin
                bnd_o = 1'b1;
                nxt_o = (SATURATE == CntrModeSat) ? '0 : limit_i;
            end
        end
    end

endmodule

// File: rtl/syn_cntr_n.sv
// Parametrised up/down counter with preset, load, programmable terminal value,
// wrap/saturate mode, compare match and sticky overflow.
module syn_cntr_n
    import syn_cntr_n_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = CntrModeWrap
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             PRE,
    input  logic             PL,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             UP,
    input  logic [WIDTH-1:0] LIMIT,
    input  logic [WIDTH-1:0] CMP,
    input  logic             OVF_CLR,
    output logic [WIDTH-1:0] Q,
    output logic             COUT,
    output logic             MATCH,
    output logic             ZERO,
    output logic             OVF
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_nxt;
    logic             step_bnd;
    cntr_op_e         op;

    syn_cntr_n_step #(
        .WIDTH   (WIDTH),
        .SATURATE(SATURATE)
    ) u_step (
        .q_i    (q_q),
        .up_i   (UP),
        .limit_i(LIMIT),
        .nxt_o  (step_nxt),
        .bnd_o  (step_bnd)
    );

    assign op = cntr_op_decode(CLR, PRE, PL, EN);

    always_comb begin
        q_d    = q_q;
        cout_d = 1'b0;
        ovf_d  = ovf_q & ~OVF_CLR;
        unique case (op)
            OpPre:   q_d = '1;
            OpLoad:  q_d = D;
            OpCount: begin
                q_d    = step_nxt;
                cout_d = step_bnd;
                // A boundary event wins over a simultaneous OVF_CLR.
                ovf_d  = ovf_d | step_bnd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            q_q    <= RESET_VAL;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Q     = q_q;
    assign COUT  = cout_q;
    assign OVF   = ovf_q;
    assign MATCH = (q_q == CMP);
    assign ZERO  = (q_q == '0);

endmodule

// File: tb/tb_syn_cntr_n.sv
// Bench for syn_cntr_n: three instances (8-bit wrap, 8-bit saturate, 4-bit wrap)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_syn_cntr_n;

    logic       CLK = 1'b0;
    logic       CLR, PRE, PL, EN, UP, OVF_CLR;
    logic [7:0] D, LIMIT, CMP;

    logic [7:0] q_w, q_s;
    logic [3:0] q_n;
    logic       cout_w, cout_s, cout_n;
    logic       match_w, match_s, match_n;
    logic       zero_w, zero_s, zero_n;
    logic       ovf_w, ovf_s, ovf_n;

    int n_chk  = 0;
    int n_pass = 0;

    int mq[3] = '{0, 0, 0};
    int mc[3] = '{0, 0, 0};
    int mo[3] = '{0, 0, 0};

    int t2q[7] = '{1, 2, 3, 4, 5, 0, 1};
    int t2c[7] = '{0, 0, 0, 0, 0, 1, 0};

    always #5 CLK = ~CLK;

    syn_cntr_n #(.WIDTH(8), .RESET_VAL(8'h00), .SATURATE(1'b0)) u_w (
        .CLK(CLK), .CLR(CLR), .PRE(PRE), .PL(PL), .D(D), .EN(EN), .UP(UP),
        .LIMIT(LIMIT), .CMP(CMP), .OVF_CLR(OVF_CLR),
        .Q(q_w), .COUT(cout_w), .MATCH(match_w), .ZERO(zero_w), .OVF(ovf_w)
    );

    syn_cntr_n #(.WIDTH(8), .RESET_VAL(8'h5A), .SATURATE(1'b1)) u_s (
        .CLK(CLK), .CLR(CLR), .PRE(PRE), .PL(PL), .D(D), .EN(EN), .UP(UP),
        .LIMIT(LIMIT), .CMP(CMP), .OVF_CLR(OVF_CLR),
        .Q(q_s), .COUT(cout_s), .MATCH(match_s), .ZERO(zero_s), .OVF(ovf_s)
    );

    syn_cntr_n #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(1'b0)) u_n (
        .CLK(CLK), .CLR(CLR), .PRE(PRE), .PL(PL), .D(D[3:0]), .EN(EN), .UP(UP),
        .LIMIT(LIMIT[3:0]), .CMP(CMP[3:0]), .OVF_CLR(OVF_CLR),
        .Q(q_n), .COUT(cout_n), .MATCH(match_n), .ZERO(zero_n), .OVF(ovf_n)
    );

    function automatic int wid(int i);
        return (i == 2) ? 4 : 8;
    endfunction

    function automatic bit sat(int i);
        return (i == 1);
    endfunction

    function automatic int rv(int i);
        return (i == 1) ? 'h5A : 0;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: value-level rules for one edge, per instance.
    always @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            int m, lim, b;
            m   = (1 << wid(i)) - 1;
            lim = int'(LIMIT) & m;
            b   = 0;
            if (CLR) begin
                mq[i] = rv(i);
                mc[i] = 0;
                mo[i] = 0;
            end else begin
                if (PRE) mq[i] = m;
                else if (PL) mq[i] = int'(D) & m;
                else if (EN) begin
                    if (UP) begin
                        if (mq[i] < lim) mq[i] = mq[i] + 1;
                        else begin b = 1; mq[i] = sat(i) ? lim : 0; end
                    end else begin
                        if (mq[i] > 0) mq[i] = mq[i] - 1;
                        else begin b = 1; mq[i] = sat(i) ? 0 : lim; end
                    end
                end
                mc[i] = b;
                if (b != 0) mo[i] = 1;
                else if (OVF_CLR) mo[i] = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        @(posedge CLK);
        forever begin
            int dq[3], dc[3], dm[3], dz[3], dov[3];
            @(negedge CLK);
            dq  = '{int'(q_w), int'(q_s), int'(q_n)};
            dc  = '{int'(cout_w), int'(cout_s), int'(cout_n)};
            dm  = '{int'(match_w), int'(match_s), int'(match_n)};
            dz  = '{int'(zero_w), int'(zero_s), int'(zero_n)};
            dov = '{int'(ovf_w), int'(ovf_s), int'(ovf_n)};
            for (int i = 0; i < 3; i++) begin
                int m;
                m = (1 << wid(i)) - 1;
                chk($sformatf("Q[%0d]", i), dq[i], mq[i]);
                chk($sformatf("COUT[%0d]", i), dc[i], mc[i]);
                chk($sformatf("OVF[%0d]", i), dov[i], mo[i]);
                chk($sformatf("MATCH[%0d]", i), dm[i], int'(mq[i] == (int'(CMP) & m)));
                chk($sformatf("ZERO[%0d]", i), dz[i], int'(mq[i] == 0));
            end
        end
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        CLR = 1'b0; PRE = 1'b0; PL = 1'b0; EN = 1'b0; OVF_CLR = 1'b0;
    endtask

    initial begin
        int pulses;
        CLR = 1'b1; PRE = 1'b0; PL = 1'b0; EN = 1'b0; UP = 1'b1; OVF_CLR = 1'b0;
        D = 8'h00; LIMIT = 8'h00; CMP = 8'h00;

        // Reset, preset, load
        cycle();
        chk("t1_q", int'(q_w), 'h00);
        chk("t1_cout", int'(cout_w), 0);
        chk("t1_ovf", int'(ovf_w), 0);
        chk("t1_q_sat_rst", int'(q_s), 'h5A);
        CLR = 1'b0; PRE = 1'b1;
        cycle();
        chk("t1_pre", int'(q_w), 'hFF);
        PRE = 1'b0; PL = 1'b1; D = 8'h3C;
        cycle();
        chk("t1_load", int'(q_w), 'h3C);

        // Wrap up with LIMIT=5
        idle(); CLR = 1'b1;
        cycle();
        CLR = 1'b0; LIMIT = 8'h05; EN = 1'b1; UP = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cycle();
            chk($sformatf("t2_q%0d", k), int'(q_w), t2q[k]);
            chk($sformatf("t2_cout%0d", k), int'(cout_w), t2c[k]);
        end
        chk("t2_ovf", int'(ovf_w), 1);

        // Wrap down, OVF_CLR vs event
        EN = 1'b0; PL = 1'b1; D = 8'h01;
        cycle();
        PL = 1'b0; EN = 1'b1; UP = 1'b0; OVF_CLR = 1'b1;
        cycle();
        chk("t3_q0", int'(q_w), 0);
        chk("t3_ovf_clr", int'(ovf_w), 0);
        cycle();
        chk("t3_q5", int'(q_w), 5);
        chk("t3_cout", int'(cout_w), 1);
        chk("t3_ovf_set_wins", int'(ovf_w), 1);
        OVF_CLR = 1'b0;
        cycle();
        chk("t3_q4", int'(q_w), 4);
        chk("t3_cout_off", int'(cout_w), 0);

        // Saturate: loaded value above LIMIT snaps and holds
        EN = 1'b0; UP = 1'b1; LIMIT = 8'h0A; PL = 1'b1; D = 8'h0F;
        cycle();
        chk("t4_load", int'(q_s), 'h0F);
        PL = 1'b0; EN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("t4_q%0d", k), int'(q_s), 'h0A);
            chk($sformatf("t4_cout%0d", k), int'(cout_s), 1);
        end

        // Priority
        CLR = 1'b1; PRE = 1'b1; PL = 1'b1; EN = 1'b1;
        cycle();
        chk("t5_clr_w", int'(q_w), 'h00);
        chk("t5_clr_s", int'(q_s), 'h5A);
        chk("t5_cout_dropped", int'(cout_s), 0);
        CLR = 1'b0; D = 8'h12; CMP = 8'hFF;
        cycle();
        chk("t5_pre_over_pl", int'(q_w), 'hFF);
        chk("t5_match", int'(match_w), 1);

        // 4-bit full-range wrap
        idle(); CLR = 1'b1; CMP = 8'h00;
        cycle();
        CLR = 1'b0; LIMIT = 8'hFF; EN = 1'b1; UP = 1'b1;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            pulses += int'(cout_n);
        end
        chk("t6_q", int'(q_n), 0);
        chk("t6_zero", int'(zero_n), 1);
        chk("t6_pulses", pulses, 1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            CLR = ($urandom_range(99) < 2);
            PRE = ($urandom_range(99) < 3);
            PL  = ($urandom_range(99) < 6);
            EN  = ($urandom_range(99) < 80);
            UP  = 1'($urandom_range(1));
            D   = 8'($urandom);
            if ($urandom_range(99) < 10) LIMIT = 8'($urandom);
            else if ($urandom_range(99) < 5) LIMIT = 8'($urandom_range(7));
            CMP = ($urandom_range(1) == 1) ? 8'(mq[0]) : 8'($urandom);
            OVF_CLR = !PRE && !PL && ($urandom_range(99) < 8);
            cycle();
        end

        idle();
        cycle();
        @(negedge CLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
